// File: rtl/chunked_complement_addsub_pkg.sv
// Shared types and sizing helpers for the chunked ones'/two's-complement adder/subtractor.
package chunked_complement_addsub_pkg;

  typedef enum logic [1:0] {IDLE, CALC, EAC, DONE} state_t;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk build still needs a one-bit counter to index with.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_complement_addsub_chunk_adder.sv
// CHUNK-bit combinational ripple-carry adder; zero latency, no flow control.
module chunked_complement_addsub_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co
);

  always_comb begin
    logic w_c;
    w_c = ci;
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ w_c;
      w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    co = w_c;
  end

endmodule

// File: rtl/chunked_complement_addsub.sv
// Multi-cycle signed add/sub, CHUNK bits per clock, done after N+1 (or 2N+1 with end-around carry) cycles;
// start ignored while busy. Optional SATURATE_EN clamps overflowed results instead of wrapping.
module chunked_complement_addsub
  import chunked_complement_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic             ones_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             neg_zero
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           r_state, w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry, r_ones;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out, r_overflow, r_neg_zero;

  logic             w_accept, w_last, w_in_eac, w_finish;
  logic [CHUNK-1:0] w_ca, w_cb, w_cs;
  logic             w_co, w_ovf, w_negz;
  logic [WIDTH-1:0] w_sum_nxt, w_final;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_cnt == LAST);
  assign w_in_eac = (r_state == EAC);

  // EAC reuses the same adder: partial result plus zero, carry-in rippling from the CALC carry.
  assign w_ca = w_in_eac ? r_sum[r_cnt*CHUNK +: CHUNK] : r_a[r_cnt*CHUNK +: CHUNK];
  assign w_cb = w_in_eac ? '0 : r_b[r_cnt*CHUNK +: CHUNK];

  chunked_complement_addsub_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a   (w_ca),
    .b   (w_cb),
    .ci  (r_carry),
    .sum (w_cs),
    .co  (w_co)
  );

  always_comb begin
    w_sum_nxt = r_sum;
    w_sum_nxt[r_cnt*CHUNK +: CHUNK] = w_cs;
  end

  assign w_finish = w_last && ((r_state == CALC && !(r_ones && w_co)) || w_in_eac);
  assign w_ovf    = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_nxt[WIDTH-1] != r_a[WIDTH-1]);

`ifdef SATURATE_EN
  assign w_final = !w_ovf ? w_sum_nxt :
                   r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_final = w_sum_nxt;
`endif

  assign w_negz = r_ones && (w_final == '1);

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = CALC;
      CALC:    if (w_last) w_next_state = (r_ones && w_co) ? EAC : DONE;
      EAC:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = start ? CALC : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_ones      <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_neg_zero  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= op_sub ? ~b : b;
        r_ones  <= ones_mode;
        r_carry <= op_sub && !ones_mode;
        r_cnt   <= '0;
        r_sum   <= '0;
      end else if (r_state == CALC || w_in_eac) begin
        r_sum   <= w_sum_nxt;
        r_carry <= w_co;
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
      // EAC is only entered on a CALC carry of 1, so that is the raw carry to report.
      if (w_finish) begin
        r_result    <= w_final;
        r_carry_out <= w_in_eac ? 1'b1 : w_co;
        r_overflow  <= w_ovf;
        r_neg_zero  <= w_negz;
      end
    end
  end

  assign busy      = (r_state == CALC) || w_in_eac;
  assign done      = (r_state == DONE);
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign neg_zero  = r_neg_zero;

endmodule

// File: tb/tb_chunked_complement_addsub.sv
// Randomized and directed self-checking bench for chunked_complement_addsub (WIDTH=8, CHUNK=4).
module tb_chunked_complement_addsub;

  localparam int W = 8;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst, start, op_sub, ones_mode;
  logic [W-1:0] a, b, result;
  logic         busy, done, carry_out, overflow, neg_zero;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_res;
  logic         exp_co, exp_ovf, exp_nz;
  int           exp_lat;

  always #5 clk = ~clk;

  chunked_complement_addsub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_sub    (op_sub),
    .ones_mode (ones_mode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .neg_zero  (neg_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: true signed values decide overflow; ones' sums fold the carry back in.
  function automatic void model(input logic sub, input logic ones,
                                input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] bp, na, nb;
    int raw, va, vb, truev, lo;
    bp  = sub ? ~bv : bv;
    na  = ~av;
    nb  = ~bv;
    raw = int'(av) + int'(bp) + ((!ones && sub) ? 1 : 0);
    exp_co = raw[W];
    if (ones) begin
      va      = av[W-1] ? -int'(na) : int'(av);
      vb      = bv[W-1] ? -int'(nb) : int'(bv);
      truev   = sub ? va - vb : va + vb;
      lo      = -(2**(W-1) - 1);
      exp_res = W'(raw + (exp_co ? 1 : 0));
      exp_lat = exp_co ? 2*N + 1 : N + 1;
    end else begin
      va      = int'($signed(av));
      vb      = int'($signed(bv));
      truev   = sub ? va - vb : va + vb;
      lo      = -(2**(W-1));
      exp_res = W'(truev);
      exp_lat = N + 1;
    end
    exp_ovf = (truev > 2**(W-1) - 1) || (truev < lo);
`ifdef SATURATE_EN
    if (exp_ovf) exp_res = av[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    exp_nz = ones && (exp_res == {W{1'b1}});
  endfunction

  task automatic launch(input logic sub, input logic ones,
                        input logic [W-1:0] av, input logic [W-1:0] bv);
    model(sub, ones, av, bv);
    op_sub = sub; ones_mode = ones; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    op_sub = 1'($urandom); ones_mode = 1'($urandom);
  endtask

  task automatic finish_op(input string tag, input int cyc0);
    int cyc;
    cyc = cyc0;
    chk({tag, ".busy"}, busy, 1);
    while (!done && cyc < 4*N + 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".lat"}, cyc, exp_lat);
    chk({tag, ".res"}, result, exp_res);
    chk({tag, ".co"}, carry_out, exp_co);
    chk({tag, ".ovf"}, overflow, exp_ovf);
    chk({tag, ".nz"}, neg_zero, exp_nz);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".hold"}, result, exp_res);
  endtask

  function automatic logic [W-1:0] pick();
    unique case ($urandom_range(5, 0))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int dcount;
    rst = 1'b0; start = 1'b0; op_sub = 1'b0; ones_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.res", result, 0);
    chk("rst.co", carry_out, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.nz", neg_zero, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    launch(1'b0, 1'b0, 8'h05, 8'h03); finish_op("two_add", 1); idle_check("two_add");
    launch(1'b1, 1'b0, 8'h03, 8'h05); finish_op("two_sub", 1); idle_check("two_sub");
    launch(1'b1, 1'b1, 8'h05, 8'h03); finish_op("ones_eac", 1); idle_check("ones_eac");
    launch(1'b1, 1'b1, 8'h05, 8'h05); finish_op("ones_nz", 1); idle_check("ones_nz");
    launch(1'b0, 1'b0, 8'h7F, 8'h01); finish_op("two_ovf", 1); idle_check("two_ovf");

    // A start pulse mid-calculation must not disturb the running operation.
    launch(1'b0, 1'b0, 8'h12, 8'h34);
    start = 1'b1; a = 8'hFF; b = 8'hFF; op_sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op("busy_ign", 2);
    idle_check("busy_ign");

    // Reset during CALC aborts without a done pulse.
    launch(1'b0, 1'b1, 8'h40, 8'h50);
    rst = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.res", result, 0);
    chk("abort.co", carry_out, 0);
    chk("abort.ovf", overflow, 0);
    chk("abort.nz", neg_zero, 0);
    dcount = 0;
    repeat (3) begin @(posedge clk); #1; if (done) dcount++; end
    rst = 1'b1;
    repeat (2*N + 2) begin @(posedge clk); #1; if (done) dcount++; end
    chk("abort.no_done", dcount, 0);
    launch(1'b1, 1'b0, 8'h20, 8'h31); finish_op("post_rst", 1); idle_check("post_rst");

    // Back-to-back: the second start is driven during the DONE cycle.
    launch(1'b0, 1'b1, 8'h7E, 8'h03); finish_op("b2b_0", 1);
    launch(1'b1, 1'b0, 8'h80, 8'h01); finish_op("b2b_1", 1); idle_check("b2b_1");

    for (int i = 0; i < 60; i++) begin
      launch(1'($urandom), 1'($urandom), pick(), pick());
      finish_op($sformatf("rnd%0d", i), 1);
      if ($urandom_range(1, 0) == 1) idle_check($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
